// File: rtl/prbs_pkg.sv
// prbs_pkg
// Shared definitions for the PRBS checker and its generator counterpart:
// pattern-select encodings, the (n,m) tap table, the data-path width, the
// checker state type and a popcount helper.
package prbs_pkg;

   localparam int PRBS_W = 32;

   // Pattern-select encodings; 9..15 are unsupported
   localparam logic [3:0] TYPE_PRBS7  = 4'd0;
   localparam logic [3:0] TYPE_PRBS9  = 4'd1;
   localparam logic [3:0] TYPE_PRBS10 = 4'd2;
   localparam logic [3:0] TYPE_PRBS11 = 4'd3;
   localparam logic [3:0] TYPE_PRBS15 = 4'd4;
   localparam logic [3:0] TYPE_PRBS20 = 4'd5;
   localparam logic [3:0] TYPE_PRBS23 = 4'd6;
   localparam logic [3:0] TYPE_PRBS29 = 4'd7;
   localparam logic [3:0] TYPE_PRBS31 = 4'd8;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } chkState_e;

   // b_k = b_(k-n) ^ b_(k-m); valid is low for unsupported selections
   typedef struct packed {
      logic [4:0] n;
      logic [4:0] m;
      logic       valid;
   } prbsTaps_t;

   function automatic prbsTaps_t getTaps(input logic [3:0] sel);
      prbsTaps_t t;
      t = '{n: 5'd0, m: 5'd0, valid: 1'b0};
      case (sel)
         TYPE_PRBS7:  t = '{n: 5'd7,  m: 5'd6,  valid: 1'b1};
         TYPE_PRBS9:  t = '{n: 5'd9,  m: 5'd5,  valid: 1'b1};
         TYPE_PRBS10: t = '{n: 5'd10, m: 5'd7,  valid: 1'b1};
         TYPE_PRBS11: t = '{n: 5'd11, m: 5'd9,  valid: 1'b1};
         TYPE_PRBS15: t = '{n: 5'd15, m: 5'd14, valid: 1'b1};
         TYPE_PRBS20: t = '{n: 5'd20, m: 5'd3,  valid: 1'b1};
         TYPE_PRBS23: t = '{n: 5'd23, m: 5'd18, valid: 1'b1};
         TYPE_PRBS29: t = '{n: 5'd29, m: 5'd27, valid: 1'b1};
         TYPE_PRBS31: t = '{n: 5'd31, m: 5'd28, valid: 1'b1};
         default:     t = '{n: 5'd0,  m: 5'd0,  valid: 1'b0};
      endcase
      return t;
   endfunction

   // Number of set bits in a data word (0..32)
   function automatic logic [5:0] countOnes(input logic [PRBS_W-1:0] v);
      logic [5:0] c;
      c = '0;
      for (int i = 0; i < PRBS_W; i++) begin
         c = c + 6'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/prbs_checker_predict.sv
// prbs_predict
// Combinational self-synchronous predictor. The previous valid word and the
// current word form one 64-bit time-ordered stream (bit 63 earliest). Bit i
// of the current word is predicted from the stream bits n and m positions
// earlier, i.e. stream[i+n] ^ stream[i+m], which is simply the stream shifted
// right by n and by m. The output is the per-bit mismatch vector.
module prbs_predict
   import prbs_pkg::*;
(
   input  logic [PRBS_W-1:0] i_hist,
   input  logic [PRBS_W-1:0] i_word,
   input  logic [3:0]        i_type,
   output logic [PRBS_W-1:0] o_mismatch,
   output logic              o_supported
);

   logic [2*PRBS_W-1:0] w_stream;
   logic [PRBS_W-1:0]   w_tapN;
   logic [PRBS_W-1:0]   w_tapM;
   prbsTaps_t           w_taps;

   assign w_taps      = getTaps(i_type);
   assign w_stream    = {i_hist, i_word};
   assign w_tapN      = PRBS_W'(w_stream >> w_taps.n);
   assign w_tapM      = PRBS_W'(w_stream >> w_taps.m);
   assign o_supported = w_taps.valid;

   // Compare each received bit against its prediction; silent when unsupported
   always_comb begin
      o_mismatch = '0;
      if (w_taps.valid) begin
         o_mismatch = i_word ^ w_tapN ^ w_tapM;
      end
   end

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker
// Self-synchronous PRBS checker with HUNT/LOCKED acquisition, a registered
// mismatch vector driving a one-cycle error flag, and saturating bit/word
// error counters that only run while locked.
// Optional build macro PRBS_CHK_INV_EN adds an i_invert input that inverts
// the received data before it reaches history and checking.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_WORDS = 16,
   parameter int LOSS_WORDS = 4
) (
   input  logic              i_clock,
   input  logic              i_init_n,
   input  logic [3:0]        i_type,
   input  logic              i_in_valid,
   input  logic [PRBS_W-1:0] i_in,
   input  logic              i_clr,
`ifdef PRBS_CHK_INV_EN
   input  logic              i_invert,
`endif
   output logic              o_locked,
   output logic              o_err_flag,
   output logic [PRBS_W-1:0] o_err_cnt,
   output logic [PRBS_W-1:0] o_err_words
);

   localparam int RUN_W  = $clog2(LOCK_WORDS + 1);
   localparam int LOSS_W = $clog2(LOSS_WORDS + 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_WORDS - 1);
   localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WORDS - 1);

   chkState_e         r_state;
   chkState_e         w_stateNext;
   logic [RUN_W-1:0]  r_runCnt;
   logic [RUN_W-1:0]  w_runNext;
   logic [LOSS_W-1:0] r_lossCnt;
   logic [LOSS_W-1:0] w_lossNext;
   logic [3:0]        r_typeQ;
   logic [PRBS_W-1:0] r_hist;
   logic              r_histOk;
   logic [PRBS_W-1:0] r_mismatch;
   logic [PRBS_W-1:0] r_errCnt;
   logic [PRBS_W-1:0] r_errWords;

   logic [PRBS_W-1:0] w_data;
   logic [PRBS_W-1:0] w_mismatch;
   logic              w_supported;
   logic              w_typeChange;
   logic              w_flush;
   logic              w_check;
   logic              w_errored;
   logic              w_countErr;
   logic [5:0]        w_popCnt;
   logic [PRBS_W:0]   w_cntSum;

`ifdef PRBS_CHK_INV_EN
   assign w_data = i_in ^ {PRBS_W{i_invert}};
`else
   assign w_data = i_in;
`endif

   prbs_predict uPredict (
      .i_hist      (r_hist),
      .i_word      (w_data),
      .i_type      (i_type),
      .o_mismatch  (w_mismatch),
      .o_supported (w_supported)
   );

   // A pattern change or an unsupported pattern throws away all sync state
   assign w_typeChange = (i_type != r_typeQ);
   assign w_flush      = w_typeChange || !w_supported;
   assign w_check      = i_in_valid && r_histOk && !w_flush;
   assign w_errored    = w_check && (|w_mismatch);
   assign w_countErr   = w_errored && (r_state == LOCKED);
   assign w_popCnt     = countOnes(w_mismatch);
   assign w_cntSum     = {1'b0, r_errCnt} + (PRBS_W+1)'(w_popCnt);

   // State register plus the lock-run and loss-run counters
   always_ff @(posedge i_clock or negedge i_init_n) begin
      if (!i_init_n) begin
         r_state   <= HUNT;
         r_runCnt  <= '0;
         r_lossCnt <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_runCnt  <= w_runNext;
         r_lossCnt <= w_lossNext;
      end
   end

   // Acquisition: count clean words in HUNT, errored words in LOCKED
   always_comb begin
      w_stateNext = r_state;
      w_runNext   = r_runCnt;
      w_lossNext  = r_lossCnt;
      if (w_flush) begin
         w_stateNext = HUNT;
         w_runNext   = '0;
         w_lossNext  = '0;
      end else if (w_check) begin
         case (r_state)
            HUNT: begin
               if (w_errored) begin
                  w_runNext = '0;
               end else if (r_runCnt == RUN_LAST) begin
                  w_stateNext = LOCKED;
                  w_runNext   = '0;
               end else begin
                  w_runNext = r_runCnt + 1'b1;
               end
            end
            LOCKED: begin
               if (!w_errored) begin
                  w_lossNext = '0;
               end else if (r_lossCnt == LOSS_LAST) begin
                  w_stateNext = HUNT;
                  w_lossNext  = '0;
               end else begin
                  w_lossNext = r_lossCnt + 1'b1;
               end
            end
            default: begin
               w_stateNext = HUNT;
               w_runNext   = '0;
               w_lossNext  = '0;
            end
         endcase
      end
   end

   // Pattern tracking and history; the first valid word after a flush only seeds
   always_ff @(posedge i_clock or negedge i_init_n) begin
      if (!i_init_n) begin
         r_typeQ  <= '0;
         r_hist   <= '0;
         r_histOk <= 1'b0;
      end else begin
         r_typeQ <= i_type;
         if (w_flush) begin
            r_histOk <= 1'b0;
         end else if (i_in_valid) begin
            r_hist   <= w_data;
            r_histOk <= 1'b1;
         end
      end
   end

   // Registered mismatch vector; zero whenever no word was checked
   always_ff @(posedge i_clock or negedge i_init_n) begin
      if (!i_init_n) begin
         r_mismatch <= '0;
      end else begin
         r_mismatch <= w_check ? w_mismatch : '0;
      end
   end

   // Saturating error counters, running only in LOCKED; clear has priority
   always_ff @(posedge i_clock or negedge i_init_n) begin
      if (!i_init_n) begin
         r_errCnt   <= '0;
         r_errWords <= '0;
      end else if (i_clr) begin
         r_errCnt   <= '0;
         r_errWords <= '0;
      end else if (w_countErr) begin
         r_errCnt <= w_cntSum[PRBS_W] ? '1 : w_cntSum[PRBS_W-1:0];
         if (r_errWords != '1) begin
            r_errWords <= r_errWords + 1'b1;
         end
      end
   end

   assign o_locked    = (r_state == LOCKED);
   assign o_err_flag  = |r_mismatch;
   assign o_err_cnt   = r_errCnt;
   assign o_err_words = r_errWords;

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LOCK_WORDS, default 16: consecutive error-free checked words needed to declare lock.
REQ-002 SHALL have parameter LOSS_WORDS, default 4: consecutive errored words, while locked, that force loss of lock.
REQ-003 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port init_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port type  input  4  pattern select: 0 PRBS7, 1 PRBS9, 2 PRBS10, 3 PRBS11, 4 PRBS15, 5 PRBS20, 6 PRBS23, 7 PRBS29, 8 PRBS31; 9-15 unsupported.
REQ-006 SHALL have port in_valid  input  1  qualifies in.
REQ-007 SHALL have port in  input  32  received word from the generator; in[31] is earliest bit in time, in[0] latest.
REQ-008 SHALL have port clr  input  1  synchronous clear of err_cnt and err_words.
REQ-009 SHALL have port locked  output  1  high while in LOCKED.
REQ-010 SHALL have port err_flag  output  1  one-cycle pulse: previous checked word had at least one mismatch.
REQ-011 SHALL have port err_cnt  output  32  saturating count of mismatched bits while locked.
REQ-012 SHALL have port err_words  output  32  saturating count of errored words while locked.

Function
REQ-013 SHALL check self-synchronously: each predicted bit b_k = b_(k-n) XOR b_(k-m), taken from the received stream (current word plus previous valid word); taps (n,m): 7/6, 9/5, 10/7, 11/9, 15/14, 20/3, 23/18, 29/27, 31/28.
REQ-014 SHALL hold a 32-bit history register and a hist_ok flag; both update only on cycles with in_valid=1.
REQ-015 SHALL not check a valid word while hist_ok=0; that word only loads history and sets hist_ok.
REQ-016 SHALL register the mismatch vector; err_flag, err_cnt and err_words reflect the word accepted in cycle t at cycle t+1.
REQ-017 SHALL implement states HUNT and LOCKED; reset state is HUNT.
REQ-018 HUNT -> LOCKED after LOCK_WORDS consecutive clean checked words; an errored word resets the run counter to 0.
REQ-019 LOCKED -> HUNT after LOSS_WORDS consecutive errored words; a clean word resets the loss counter to 0.
REQ-020 SHALL increment err_cnt by the popcount (0-32) of the mismatch vector and err_words by 1 per errored word, only in LOCKED; both saturate at 0xFFFFFFFF.
REQ-021 SHALL keep err_flag active in HUNT and LOCKED; counters are not updated in HUNT.
REQ-022 SHALL detect a change of type against the registered type_q and, in that cycle, go to HUNT, clear hist_ok and both run counters; counters are kept.
REQ-023 SHALL treat unsupported type as: stay in HUNT, locked=0, err_flag=0, no checking.
REQ-024 clr and a counted error in the same cycle: clr wins; both counters read 0 next cycle.
REQ-025 in_valid=0 cycles SHALL not affect history, run counters or outputs except err_flag=0.

Reset
REQ-026 init_n low SHALL asynchronously force HUNT, locked=0, err_flag=0, err_cnt=0, err_words=0, hist_ok=0, history=0, run counters=0, type_q=0.
REQ-027 Reset release SHALL be taken synchronously; the first valid word after release only seeds history.

Configuration
REQ-028 With PRBS_CHK_INV_EN defined, SHALL add input port invert (1 bit); when high, in is XORed with all-ones before history and checking.
REQ-029 Without PRBS_CHK_INV_EN, SHALL have no invert port; data checked as received.

Structure
REQ-030 Package prbs_pkg SHALL hold the type encodings, tap table (n,m) per type, and the PRBS_W=32 width constant, shared with prbs_generator.
REQ-031 Sub-module prbs_predict (combinational: history, word, type -> 32-bit mismatch vector) SHALL hold the tap logic; prbs_checker holds state, counters and FSM.

Verification
REQ-032 PRBS7 generator stream, in_valid=1 constantly: locked rises the cycle after the 17th valid word; err_cnt stays 0.
REQ-033 Locked PRBS31, flip in[0] of one word: err_flag pulses once, err_cnt=3 and err_words=2 after the next word.
REQ-034 Locked PRBS15, feed 4 words of 0xA5A5A5A5: locked falls after the 4th; correct stream relocks after 16 clean words.
REQ-035 Locked PRBS23, change type to 4 then to 12: locked=0 next cycle, counters unchanged; with 12 no lock ever, err_flag stays 0.
REQ-036 err_cnt preloaded near saturation via repeated errors, then clr with simultaneous error: err_cnt=0, err_words=0 next cycle.
REQ-037 init_n pulsed low mid-stream while locked: all outputs 0 immediately; lock reacquired after 17 valid words; with PRBS_CHK_INV_EN and invert=1, an inverted PRBS9 stream locks with err_cnt=0.
